// File: rtl/fifo_wide_to_bit.sv
// Width-converting FIFO: WIDTH_IN-bit words in, single bits out, LSB of each word first.
// Show-ahead read port; occupancy is reported both in word slots and in unread bits.
module fifo_wide_to_bit #(
    parameter int WIDTH_IN = 2,
    parameter int DEPTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic [WIDTH_IN-1:0]                   din,
    input  logic                                  din_valid,
    output logic                                  din_ready,
    output logic                                  dout,
    output logic                                  dout_valid,
    input  logic                                  dout_ready,
    output logic [$clog2(DEPTH):0]                word_count,
    output logic [$clog2(DEPTH*WIDTH_IN):0]       bit_count,
    output logic                                  empty,
    output logic                                  full
);

    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = $clog2(WIDTH_IN);
    localparam int WCW = AW + 1;
    localparam int BCW = $clog2(DEPTH*WIDTH_IN) + 1;

    logic [WIDTH_IN-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW+BW-1:0]    rd_ptr;     // {word index, bit index}: one increment per bit read
    logic [AW-1:0]       rd_word;
    logic [BW-1:0]       rd_bit;

    logic                wr_en;
    logic                rd_en;
    logic                word_done;
    logic [WCW-1:0]      word_count_next;
    logic [BCW-1:0]      bit_count_next;

    assign rd_word = rd_ptr[AW+BW-1:BW];
    assign rd_bit  = rd_ptr[BW-1:0];

    // Status is decoded from the counter registers only, so no input reaches an output.
    assign empty      = (bit_count == '0);
    assign full       = (word_count == WCW'(DEPTH));
    assign din_ready  = !full;
    assign dout_valid = !empty;
    assign dout       = dout_valid ? mem[rd_word][rd_bit] : 1'b0;

    assign wr_en     = din_valid && din_ready && !clear;
    assign rd_en     = dout_valid && dout_ready && !clear;
    assign word_done = rd_en && (rd_bit == BW'(WIDTH_IN - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_count_next = word_count;
        bit_count_next  = bit_count;
        if (wr_en) begin
            word_count_next = word_count_next + WCW'(1);
            bit_count_next  = bit_count_next + BCW'(WIDTH_IN);
        end
        if (word_done) word_count_next = word_count_next - WCW'(1);
        if (rd_en)     bit_count_next  = bit_count_next - BCW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_count <= '0;
            bit_count  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_count <= '0;
            bit_count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+BW)'(1);
            word_count <= word_count_next;
            bit_count  <= bit_count_next;
        end
    end

    // NOTE: the storage array has no reset; its contents are meaningless until the counters say otherwise.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule
